// File: rtl/bcd_display_formatter.sv
// Iterative binary-to-BCD converter (double dabble) feeding a 4-digit
// seven-segment driver. One shift-add-3 iteration per clock. bcd_out and
// overflow change only in the single DONE cycle, so the display never shows
// a partially converted value.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   bin_in   in   BIN_W  unsigned binary value, sampled when start is accepted
//   start    in   1      conversion request, accepted only when idle
//   busy     out  1      high while shifting and in the done cycle
//   done     out  1      one-cycle pulse, bcd_out/overflow updated this cycle
//   overflow out  1      last completed conversion exceeded MAX_VAL
//   bcd_out  out  16     {thousands, hundreds, tens, ones}
module bcd_display_formatter #(
    parameter int unsigned BIN_W   = 16,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [15:0]      bcd_out
);

    localparam int unsigned BCD_W = 16;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [BIN_W-1:0]   bin_sr, bin_sr_next;
    logic [BCD_W-1:0]   acc, acc_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               ovf_pend, ovf_pend_next;
    logic [BCD_W-1:0]   bcd_out_next;
    logic               overflow_next;
    logic [BCD_W-1:0]   acc_adj_c;
    logic [CNT_W-1:0]   cnt_dec_c;

    // Add 3 to every nibble that is 5 or more, all four in parallel.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            bin_sr   <= bin_sr_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            ovf_pend <= ovf_pend_next;
            bcd_out  <= bcd_out_next;
            overflow <= overflow_next;
            done     <= (state_next == DONE);
            busy     <= (state_next != IDLE);
        end
    end

    // Next-state and next-value logic.
    always_comb begin
        state_next    = state;
        bin_sr_next   = bin_sr;
        acc_next      = acc;
        cnt_next      = cnt;
        ovf_pend_next = ovf_pend;
        bcd_out_next  = bcd_out;
        overflow_next = overflow;
        acc_adj_c     = add3(acc);
        cnt_dec_c     = cnt - CNT_W'(1);

        unique case (state)
            IDLE: begin
                if (start) begin
                    bin_sr_next   = bin_in;
                    acc_next      = '0;
                    cnt_next      = CNT_W'(BIN_W);
                    ovf_pend_next = (bin_in > BIN_W'(MAX_VAL));
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                acc_next    = {acc_adj_c[BCD_W-2:0], bin_sr[BIN_W-1]};
                bin_sr_next = {bin_sr[BIN_W-2:0], 1'b0};
                cnt_next    = cnt_dec_c;
                if (cnt_dec_c == '0) begin
                    // Final iteration: load the output register on this same edge.
                    state_next    = DONE;
                    bcd_out_next  = ovf_pend ? 16'hFFFF
                                             : {acc_adj_c[BCD_W-2:0], bin_sr[BIN_W-1]};
                    overflow_next = ovf_pend;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Randomized self-checking bench for bcd_display_formatter.
module tb_bcd_display_formatter;

    localparam int unsigned BIN_W = 16;
    localparam int LATENCY = 16;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst_n;
    logic [BIN_W-1:0] bin_in;
    logic             start;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [15:0]      bcd_out;

    int checks = 0;
    int errors = 0;

    bcd_display_formatter #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd_out  (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by division, overflow shown as FFFF.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        if (v > 9999) return 16'hFFFF;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Runs one conversion starting just after a rising edge in IDLE.
    // Checks hold behaviour during SHIFT, latency and the done pulse width.
    task automatic do_conv(input logic [15:0] v, input string name,
                           output logic [15:0] r_bcd, output logic r_ovf);
        logic [15:0] prev_bcd;
        logic        prev_ovf;
        int          lat;
        bit          hold_bad;
        prev_bcd = bcd_out;
        prev_ovf = overflow;
        hold_bad = 1'b0;
        bin_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (bcd_out !== prev_bcd || overflow !== prev_ovf || busy !== 1'b1)
                hold_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL %s hold: outputs changed or busy low during shift (prev bcd %h)", name, prev_bcd);
        end
        checks++;
        if (lat != LATENCY) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, LATENCY);
        end
        r_bcd = bcd_out;
        r_ovf = overflow;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b, expected 1", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_end: done=%b busy=%b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic check_conv(input int unsigned v, input string name);
        logic [15:0] got;
        logic        gov;
        logic [15:0] exp_b;
        do_conv(16'(v), name, got, gov);
        exp_b = ref_bcd(v);
        checks++;
        if (got !== exp_b || gov !== (v > 9999)) begin
            errors++;
            $display("FAIL %s value %0d: got bcd=%h ovf=%b, expected bcd=%h ovf=%b",
                     name, v, got, gov, exp_b, (v > 9999));
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bcd_out !== 16'h0000 || overflow !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: bcd=%h ovf=%b done=%b busy=%b, expected 0000 0 0 0",
                     bcd_out, overflow, done, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        check_conv(0, "zero");
        check_conv(1234, "v1234");
        check_conv(9999, "max");
        check_conv(10000, "over");
        check_conv(7, "after_over");
        check_conv(65535, "all_ones");
    endtask

    task automatic test_random();
        int unsigned v;
        for (int i = 0; i < 20; i++) begin
            v = (i % 4 == 3) ? ($urandom % 65536) : $urandom_range(0, 10050);
            check_conv(v, "random");
        end
    endtask

    // start held high: done every BIN_W+2 cycles, one cycle wide.
    task automatic test_back_to_back();
        int pulses[$];
        bit prev_done;
        bit wide;
        prev_done = 1'b0;
        wide = 1'b0;
        bin_in = 16'd42;
        start  = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses.push_back(c);
                if (prev_done) wide = 1'b1;
                checks++;
                if (bcd_out !== 16'h0042 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b value: got %h ovf=%b, expected 0042 0", bcd_out, overflow);
                end
            end
            prev_done = (done === 1'b1);
        end
        start = 1'b0;
        checks++;
        if (pulses.size() != 3 || wide) begin
            errors++;
            $display("FAIL b2b pulses: got %0d pulses (wide=%b), expected 3 single-cycle", pulses.size(), wide);
        end else begin
            checks++;
            if (pulses[0] != 17 || pulses[1] - pulses[0] != 18 || pulses[2] - pulses[1] != 18) begin
                errors++;
                $display("FAIL b2b spacing: got %0d %0d %0d, expected 17 35 53",
                         pulses[0], pulses[1], pulses[2]);
            end
        end
    endtask

    // bin_in change during SHIFT must not affect the result.
    task automatic test_bin_change();
        int lat;
        bin_in = 16'd500;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bin_in = 16'd900;
        lat = 3;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (done !== 1'b1 || bcd_out !== 16'h0500) begin
            errors++;
            $display("FAIL bin_change: done=%b bcd=%h, expected 1 0500", done, bcd_out);
        end
        @(posedge clk); #1;
    endtask

    // Reset mid-conversion: outputs clear asynchronously, no done pulse.
    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 1'b0;
        bin_in = 16'd4321;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bcd_out !== 16'h0000 || overflow !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: bcd=%h ovf=%b done=%b busy=%b, expected 0000 0 0 0",
                     bcd_out, overflow, done, busy);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid no_done: got activity after reset, expected none");
        end
        check_conv(4321, "after_reset");
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_back_to_back();
        test_bin_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
